// File: rtl/noc_inject_arbiter_pkg.sv
// Shared types and constants for the NoC injection arbiter.
// Provides Noc_Data_Width / Noc_Arb_Cnt_Width defaults when the shared parameter include is absent.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_Arb_Cnt_Width
`define Noc_Arb_Cnt_Width 16
`endif

package noc_inject_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   localparam int ARB_CNT_W = `Noc_Arb_Cnt_Width;

   // Round-robin pointer advance: one past the winner, wrapping at n.
   function automatic int rr_next(input int id, input int n);
      return (id + 1 >= n) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/noc_rr_picker.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping mod N.
module noc_rr_picker #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt_onehot,
   output logic [ID_W-1:0] gnt_id,
   output logic            any
);

   logic [ID_W:0]   w_sum;
   logic [ID_W-1:0] w_idx;

   // Scan from farthest to nearest so the closest-to-ptr request wins.
   always_comb begin
      gnt_onehot = '0;
      gnt_id     = '0;
      any        = 1'b0;
      w_sum      = '0;
      w_idx      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_sum = {1'b0, ptr} + (ID_W + 1)'(k);
         if (w_sum >= (ID_W + 1)'(N)) w_sum = w_sum - (ID_W + 1)'(N);
         w_idx = w_sum[ID_W-1:0];
         if (req[w_idx]) begin
            gnt_onehot        = '0;
            gnt_onehot[w_idx] = 1'b1;
            gnt_id            = w_idx;
            any               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter feeding one router local injection port (wormhole lock header..tail).
// Optional per-requester packet counters are built when NOC_INJ_ARB_STATS_EN is defined.
//
// state     | meaning
// ST_IDLE   | arbitrating among requesters offering a header flit
// ST_LOCKED | multi-flit packet in flight, mux held on grant_id until its tail handshakes
module noc_inject_arbiter
   import noc_inject_arbiter_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = `Noc_Data_Width,
   parameter int ID_W   = $clog2(N_REQ)
) (
   input  logic                    noc_clk,
   input  logic                    noc_rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DATA_W-1:0] req_flit,
   input  logic [N_REQ-1:0]        req_is_header,
   input  logic [N_REQ-1:0]        req_is_tail,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_flit,
   output logic                    out_is_header,
   output logic                    out_is_tail,
   output logic                    busy,
   output logic [ID_W-1:0]         grant_id,
   output logic                    err_hdr
`ifdef NOC_INJ_ARB_STATS_EN
   ,
   input  logic                       stats_clr,
   output logic [N_REQ*ARB_CNT_W-1:0] pkt_cnt
`endif
);

   arb_state_t       r_state;
   logic [ID_W-1:0]  r_rr_ptr;
   logic [ID_W-1:0]  r_grant_id;
   logic             r_busy;
   logic             r_err_hdr;

   logic [N_REQ-1:0] w_eligible;
   logic [N_REQ-1:0] w_stray;
   logic [N_REQ-1:0] w_pick_oh;
   logic [ID_W-1:0]  w_pick_id;
   logic             w_any;
   logic [ID_W-1:0]  w_sel;
   logic             w_sel_valid;
   logic             w_xfer;

   assign w_eligible = req_valid & req_is_header;
   assign w_stray    = req_valid & ~req_is_header;

   noc_rr_picker #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_picker (
      .req        (w_eligible),
      .ptr        (r_rr_ptr),
      .gnt_onehot (w_pick_oh),
      .gnt_id     (w_pick_id),
      .any        (w_any)
   );

   assign w_sel         = (r_state == ST_LOCKED) ? r_grant_id : w_pick_id;
   assign w_sel_valid   = (r_state == ST_LOCKED) ? req_valid[w_sel] : w_any;
   assign out_valid     = w_sel_valid & ~noc_rst;
   assign out_flit      = req_flit[w_sel*DATA_W +: DATA_W];
   assign out_is_header = req_is_header[w_sel];
   assign out_is_tail   = req_is_tail[w_sel];
   assign w_xfer        = out_valid & out_ready;

   // Non-header flits arriving while unlocked are swallowed so they cannot wedge a requester.
   always_comb begin
      req_ready = '0;
      if (!noc_rst) begin
         if (r_state == ST_LOCKED) req_ready[r_grant_id] = out_ready;
         else                      req_ready = (w_pick_oh & {N_REQ{out_ready}}) | w_stray;
      end
   end

   always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
         r_err_hdr  <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (|w_stray) r_err_hdr <= 1'b1;
         if (w_xfer) begin
            r_rr_ptr   <= ID_W'(rr_next(int'(w_pick_id), N_REQ));
            r_grant_id <= w_pick_id;
            if (!out_is_tail) begin
               r_state <= ST_LOCKED;
               r_busy  <= 1'b1;
            end
         end
      end else begin
         if (w_xfer) begin
            if (out_is_header) r_err_hdr <= 1'b1;
            if (out_is_tail) begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         end
      end
   end

   assign busy     = r_busy;
   assign grant_id = r_grant_id;
   assign err_hdr  = r_err_hdr;

`ifdef NOC_INJ_ARB_STATS_EN
   logic [ARB_CNT_W-1:0] r_pkt_cnt [N_REQ];

   // Clear beats a coincident increment; counters stick at all-ones.
   always_ff @(posedge noc_clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (noc_rst || stats_clr)
            r_pkt_cnt[i] <= '0;
         else if (w_xfer && out_is_tail && (w_sel == ID_W'(i)) && (r_pkt_cnt[i] != '1))
            r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
      assign pkt_cnt[g*ARB_CNT_W +: ARB_CNT_W] = r_pkt_cnt[g];
   end
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed self-checking bench for noc_inject_arbiter (N_REQ=4, 32-bit flits).
// Flit payload = {requester id, packet number, flit position, 8'hA5}.
module tb_noc_inject_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic              noc_clk = 1'b0;
   logic              noc_rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*DW-1:0]   req_flit;
   logic [N-1:0]      req_is_header;
   logic [N-1:0]      req_is_tail;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_flit;
   logic              out_is_header;
   logic              out_is_tail;
   logic              busy;
   logic [1:0]        grant_id;
   logic              err_hdr;
`ifdef NOC_INJ_ARB_STATS_EN
   logic              stats_clr;
   logic [N*16-1:0]   pkt_cnt;
`endif

   always #5 noc_clk = ~noc_clk;

   noc_inject_arbiter #(
      .N_REQ  (N),
      .DATA_W (DW)
   ) dut (
      .noc_clk       (noc_clk),
      .noc_rst       (noc_rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_flit      (req_flit),
      .req_is_header (req_is_header),
      .req_is_tail   (req_is_tail),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_flit      (out_flit),
      .out_is_header (out_is_header),
      .out_is_tail   (out_is_tail),
      .busy          (busy),
      .grant_id      (grant_id),
      .err_hdr       (err_hdr)
`ifdef NOC_INJ_ARB_STATS_EN
      ,
      .stats_clr     (stats_clr),
      .pkt_cnt       (pkt_cnt)
`endif
   );

   int src_en  [N];
   int src_len [N];
   int src_pos [N];
   int src_pkt [N];
   int src_rem [N];
   logic [DW-1:0] obs_q [$];
   int n_tests = 0;
   int n_fail  = 0;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = (src_en[i] != 0);
         req_is_header[i]      = (src_pos[i] == 0);
         req_is_tail[i]        = (src_pos[i] == src_len[i] - 1);
         req_flit[i*DW +: DW]  = {8'(i), 8'(src_pkt[i]), 8'(src_pos[i]), 8'hA5};
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, advance the requester sources after it.
   task automatic tick();
      logic [N-1:0] hs;
      #1;
      hs = req_valid & req_ready;
      if (out_valid && out_ready) obs_q.push_back(out_flit);
      @(posedge noc_clk);
      @(negedge noc_clk);
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            if (src_pos[i] == src_len[i] - 1) begin
               src_pos[i] = 0;
               src_pkt[i]++;
               if (src_rem[i] > 0) begin
                  src_rem[i]--;
                  if (src_rem[i] == 0) src_en[i] = 0;
               end
            end else begin
               src_pos[i]++;
            end
         end
      end
   endtask

   task automatic start(input int i, input int len, input int npkt);
      src_en[i]  = 1;
      src_len[i] = len;
      src_pos[i] = 0;
      src_rem[i] = npkt;
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int n;
      n = 0;
      while (((src_en[0] | src_en[1] | src_en[2] | src_en[3]) != 0 || busy) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done"}, 32'(n < budget), 32'd1);
   endtask

   // Compare the observed flit stream against expected (id, position) pairs.
   task automatic check_obs(input string tag, input int exp_id[$], input int exp_pos[$]);
      logic [15:0] got;
      check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_id.size()));
      for (int k = 0; k < exp_id.size(); k++) begin
         got = (k < obs_q.size()) ? {obs_q[k][31:24], obs_q[k][15:8]} : 16'hFFFF;
         check({tag, "_flit"}, 32'(got), {16'h0, 8'(exp_id[k]), 8'(exp_pos[k])});
      end
      obs_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ei[$];
      int ep[$];
      int t3_exp[4] = '{1, 3, 1, 3};
      int c;

      noc_rst   = 1'b1;
      out_ready = 1'b0;
`ifdef NOC_INJ_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      @(negedge noc_clk);
      tick(); tick(); tick();
      noc_rst = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gid", 32'(grant_id), 32'd0);
      check("rst_err", 32'(err_hdr), 32'd0);
      check("rst_ovalid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;

      // 1: four requesters, two 3-flit packets each, back to back
      for (int i = 0; i < N; i++) start(i, 3, 2);
      run_until_done("t1", 60);
      ei.delete(); ep.delete();
      for (int k = 0; k < 24; k++) begin
         ei.push_back((k / 3) % 4);
         ep.push_back(k % 3);
      end
      check_obs("t1", ei, ep);
      check("t1_gid", 32'(grant_id), 32'd3);

      // 2: header from req 0 must wait behind req 2's locked packet
      start(2, 4, 1);
      tick();
      check("t2_busy", 32'(busy), 32'd1);
      check("t2_gid", 32'(grant_id), 32'd2);
      start(0, 2, 1);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t2_hold_rdy0", 32'(req_ready[0]), 32'd0);
         check("t2_out_id", 32'(out_flit[31:24]), 32'd2);
         tick();
      end
      #1;
      check("t2_rdy0_after", 32'(req_ready[0]), 32'd1);
      tick();
      check("t2_gid0", 32'(grant_id), 32'd0);
      check("t2_busy0", 32'(busy), 32'd1);
      tick();
      check("t2_idle", 32'(busy), 32'd0);
      ei = '{2, 2, 2, 2, 0, 0};
      ep = '{0, 1, 2, 3, 0, 1};
      check_obs("t2", ei, ep);

      // 3: single-flit packets from reqs 1 and 3, one per cycle
      start(1, 1, 2);
      start(3, 1, 2);
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t3_busy", 32'(busy), 32'd0);
         check("t3_ovalid", 32'(out_valid), 32'd1);
         tick();
         check("t3_gid", 32'(grant_id), 32'(t3_exp[k]));
      end
      ei = '{1, 3, 1, 3};
      ep = '{0, 0, 0, 0};
      check_obs("t3", ei, ep);

      // 4: 5-flit packet with out_ready toggling 1010...
      start(2, 5, 1);
      c = 0;
      while (src_en[2] != 0 && c < 30) begin
         out_ready = (c % 2 == 0);
         tick();
         if (c == 0) check("t4_busy", 32'(busy), 32'd1);
         c++;
      end
      out_ready = 1'b1;
      check("t4_done", 32'(c < 30), 32'd1);
      check("t4_busy_end", 32'(busy), 32'd0);
      ei = '{2, 2, 2, 2, 2};
      ep = '{0, 1, 2, 3, 4};
      check_obs("t4", ei, ep);

      // 5: non-header flits while unlocked are dropped and flag err_hdr
      start(0, 3, 1);
      src_pos[0] = 1;
      #1;
      check("t5_ovalid", 32'(out_valid), 32'd0);
      check("t5_rdy0", 32'(req_ready[0]), 32'd1);
      check("t5_err_pre", 32'(err_hdr), 32'd0);
      tick();
      check("t5_err", 32'(err_hdr), 32'd1);
      tick();
      start(3, 1, 1);
      tick();
      check("t5_err_held", 32'(err_hdr), 32'd1);
      ei = '{3};
      ep = '{0};
      check_obs("t5", ei, ep);

      // 6: reset in the middle of a 4-flit packet
      start(1, 4, 1);
      tick();
      tick();
      check("t6_busy_pre", 32'(busy), 32'd1);
      check("t6_gid_pre", 32'(grant_id), 32'd1);
      noc_rst = 1'b1;
      #1;
      check("t6_rst_ovalid", 32'(out_valid), 32'd0);
      check("t6_rst_rdy", 32'(req_ready), 32'd0);
      tick();
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_gid", 32'(grant_id), 32'd0);
      check("t6_err", 32'(err_hdr), 32'd0);
      noc_rst = 1'b0;
      src_en[1] = 0;
      src_pos[1] = 0;
      obs_q.delete();
      start(3, 1, 1);
      start(1, 1, 1);
      tick();
      check("t6_post_gid1", 32'(grant_id), 32'd1);
      tick();
      check("t6_post_gid3", 32'(grant_id), 32'd3);
      obs_q.delete();

`ifdef NOC_INJ_ARB_STATS_EN
      check("st_cnt1", 32'(pkt_cnt[16 +: 16]), 32'd1);
      check("st_cnt3", 32'(pkt_cnt[48 +: 16]), 32'd1);
      start(1, 1, 70000);
      run_until_done("st_sat", 70100);
      check("st_sat_cnt1", 32'(pkt_cnt[16 +: 16]), 32'hFFFF);
      start(3, 1, 1);
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      check("st_clr_cnt3", 32'(pkt_cnt[48 +: 16]), 32'd0);
      check("st_clr_cnt1", 32'(pkt_cnt[16 +: 16]), 32'd0);
      obs_q.delete();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
